// File: rtl/ft3_spi_lane_arbiter_if.sv
// Lane-arbitration bundle between the FT3/SPI requesters (master) and the arbiter (slave).
// LANE_ARB_STATS_EN adds the statistics clear input and the two counters.
interface ft3_spi_lane_arbiter_if;
   logic       ft3_busy;
   logic       spi_req;
   logic       spi_done;
   logic       spi_grant;
   logic       ft3_grant;
   logic       spi_switch;
   logic       spi_timeout;
   logic [1:0] arb_state;
`ifdef LANE_ARB_STATS_EN
   logic        stats_clr;
   logic [15:0] spi_grant_cnt;
   logic [15:0] spi_timeout_cnt;

   modport master (output ft3_busy, spi_req, spi_done, stats_clr,
                   input  spi_grant, ft3_grant, spi_switch, spi_timeout, arb_state,
                          spi_grant_cnt, spi_timeout_cnt);
   modport slave  (input  ft3_busy, spi_req, spi_done, stats_clr,
                   output spi_grant, ft3_grant, spi_switch, spi_timeout, arb_state,
                          spi_grant_cnt, spi_timeout_cnt);
`else
   modport master (output ft3_busy, spi_req, spi_done,
                   input  spi_grant, ft3_grant, spi_switch, spi_timeout, arb_state);
   modport slave  (input  ft3_busy, spi_req, spi_done,
                   output spi_grant, ft3_grant, spi_switch, spi_timeout, arb_state);
`endif
endinterface

// File: rtl/ft3_spi_lane_arbiter.sv
// Time-shares the DDR LVDS lane between FT3 (default owner) and the SPI tunnel with guard
// intervals on every handover. Optional grant/timeout statistics: define LANE_ARB_STATS_EN.
module ft3_spi_lane_arbiter #(
   parameter int GUARD_CYC   = 4,
   parameter int FT3_MIN_CYC = 16,
   parameter int SPI_MAX_CYC = 1024
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   ft3_spi_lane_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      FT3_OWN      = 2'b00,
      GUARD_TO_SPI = 2'b01,
      SPI_OWN      = 2'b10,
      GUARD_TO_FT3 = 2'b11
   } state_e;

   localparam int GW = $clog2(GUARD_CYC) + 1;
   localparam int HW = $clog2(FT3_MIN_CYC) + 1;
   localparam int OW = $clog2(SPI_MAX_CYC) + 1;

   localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);
   localparam logic [HW-1:0] HOLD_MAX   = HW'(FT3_MIN_CYC);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(FT3_MIN_CYC - 1);
   localparam logic [OW-1:0] OCC_LAST   = OW'(SPI_MAX_CYC - 1);

   state_e        state_q;
   logic [GW-1:0] guard_q;
   logic [HW-1:0] hold_q;
   logic [OW-1:0] occ_q;
   logic          abandon_q;
   logic          ft3_grant_q, spi_grant_q, spi_switch_q, spi_timeout_q;

   logic guard_last, hold_ok, take_lane, spi_enter, spi_release, to_event;

   // hold_ok covers the current cycle, so FT3 keeps the lane for FT3_MIN_CYC full cycles.
   assign guard_last  = (guard_q == GUARD_LAST);
   assign hold_ok     = (hold_q >= HOLD_LAST);
   assign take_lane   = (state_q == FT3_OWN) && bus.spi_req && !bus.ft3_busy && hold_ok;
   assign spi_enter   = (state_q == GUARD_TO_SPI) && guard_last && !abandon_q && bus.spi_req;
   assign spi_release = (state_q == SPI_OWN) && (bus.spi_done || occ_q == OCC_LAST);
   assign to_event    = (state_q == SPI_OWN) && (occ_q == OCC_LAST) && !bus.spi_done;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= FT3_OWN;
         guard_q       <= '0;
         hold_q        <= HOLD_MAX;
         occ_q         <= '0;
         abandon_q     <= 1'b0;
         ft3_grant_q   <= 1'b1;
         spi_grant_q   <= 1'b0;
         spi_switch_q  <= 1'b0;
         spi_timeout_q <= 1'b0;
      end else begin
         spi_timeout_q <= 1'b0;
         case (state_q)
            FT3_OWN: begin
               if (hold_q != HOLD_MAX) hold_q <= hold_q + HW'(1);
               if (take_lane) begin
                  state_q      <= GUARD_TO_SPI;
                  guard_q      <= '0;
                  abandon_q    <= 1'b0;
                  ft3_grant_q  <= 1'b0;
                  spi_switch_q <= 1'b1;
               end
            end
            GUARD_TO_SPI: begin
               if (guard_last) begin
                  guard_q <= '0;
                  if (spi_enter) begin
                     state_q     <= SPI_OWN;
                     occ_q       <= '0;
                     spi_grant_q <= 1'b1;
                  end else begin
                     state_q <= GUARD_TO_FT3;
                  end
               end else begin
                  guard_q <= guard_q + GW'(1);
                  if (!bus.spi_req) abandon_q <= 1'b1;
               end
            end
            SPI_OWN: begin
               if (spi_release) begin
                  state_q       <= GUARD_TO_FT3;
                  guard_q       <= '0;
                  spi_grant_q   <= 1'b0;
                  spi_timeout_q <= to_event;
               end else begin
                  occ_q <= occ_q + OW'(1);
               end
            end
            GUARD_TO_FT3: begin
               if (guard_last) begin
                  state_q      <= FT3_OWN;
                  guard_q      <= '0;
                  hold_q       <= '0;
                  spi_switch_q <= 1'b0;
                  ft3_grant_q  <= 1'b1;
               end else begin
                  guard_q <= guard_q + GW'(1);
               end
            end
            default: state_q <= FT3_OWN;
         endcase
      end
   end

   assign bus.ft3_grant   = ft3_grant_q;
   assign bus.spi_grant   = spi_grant_q;
   assign bus.spi_switch  = spi_switch_q;
   assign bus.spi_timeout = spi_timeout_q;
   assign bus.arb_state   = state_q;

`ifdef LANE_ARB_STATS_EN
   logic [15:0] grant_cnt_q, to_cnt_q;

   // A clear wins over an increment landing on the same edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         grant_cnt_q <= '0;
         to_cnt_q    <= '0;
      end else if (bus.stats_clr) begin
         grant_cnt_q <= '0;
         to_cnt_q    <= '0;
      end else begin
         if (spi_enter && grant_cnt_q != 16'hFFFF) grant_cnt_q <= grant_cnt_q + 16'd1;
         if (to_event && to_cnt_q != 16'hFFFF)     to_cnt_q    <= to_cnt_q + 16'd1;
      end
   end

   assign bus.spi_grant_cnt   = grant_cnt_q;
   assign bus.spi_timeout_cnt = to_cnt_q;
`endif
endmodule

// File: tb/tb_ft3_spi_lane_arbiter.sv
// Randomized bench: the stimulus derives expected lane events (cycle numbers) from the
// arbitration rules and queues them; a negedge monitor matches observed output edges.
module tb_ft3_spi_lane_arbiter;
   localparam int G    = 4;
   localparam int HMIN = 16;
   localparam int MAX  = 24;

   localparam int K_NORM = 0, K_TO = 1, K_COIN = 2, K_ABAN = 3;
   localparam int E_SWUP = 0, E_GUP = 1, E_GDN = 2, E_TO = 3, E_FUP = 4;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   ev_t  exp_q[$];
   int   ft3_start = -1000;
   int   n_grants = 0;
   int   n_tos = 0;
   bit   p_sw, p_gnt, p_ft3;

   ft3_spi_lane_arbiter_if bus();

   ft3_spi_lane_arbiter #(.GUARD_CYC(G), .FT3_MIN_CYC(HMIN), .SPI_MAX_CYC(MAX)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   function automatic void push_ev(input int kind, input int c);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      exp_q.push_back(e);
   endfunction

   task automatic got(input int kind);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event kind %0d at cycle %0d", kind, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != cyc) begin
            errors++;
            $display("FAIL event: got kind %0d at cycle %0d expected kind %0d at cycle %0d",
                     kind, cyc, e.kind, e.cyc);
         end
      end
   endtask

   // Monitor: invariants every cycle, plus output edges matched against the queue.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("grant_excl", int'(bus.spi_grant && bus.ft3_grant), 0);
         chk("ft3_vs_switch", int'(bus.ft3_grant), int'(!bus.spi_switch));
         if (bus.ft3_grant)      chk("state_ft3", int'(bus.arb_state), 0);
         else if (bus.spi_grant) chk("state_spi", int'(bus.arb_state), 2);
         else                    chk("state_guard", int'(bus.arb_state[0]), 1);
         if (bus.spi_switch && !p_sw)  got(E_SWUP);
         if (bus.spi_grant && !p_gnt)  got(E_GUP);
         if (!bus.spi_grant && p_gnt)  got(E_GDN);
         if (bus.spi_timeout)          got(E_TO);
         if (bus.ft3_grant && !p_ft3)  got(E_FUP);
      end
      p_sw  = bus.spi_switch;
      p_gnt = bus.spi_grant;
      p_ft3 = bus.ft3_grant;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // FT3 may hand over once it has owned the lane HMIN cycles and no frame is in progress.
   function automatic int handover_cycle(input int c0, input int b);
      int t;
      t = c0 + b;
      if (ft3_start + HMIN - 1 > t) t = ft3_start + HMIN - 1;
      return t;
   endfunction

   task automatic run_txn(input int kind, input int b, input int d, input int k, input int gap);
      int c0, t, tg, len, tr, end_c;
      c0 = cyc;
      t  = handover_cycle(c0, b);
      tg = t + 1 + G;
      len = (kind == K_TO || kind == K_COIN) ? MAX : d;
      tr = tg + len;
      push_ev(E_SWUP, t + 1);
      if (kind == K_ABAN) begin
         end_c = t + 1 + 2 * G;
         push_ev(E_FUP, end_c);
      end else begin
         end_c = tr;
         push_ev(E_GUP, tg);
         push_ev(E_GDN, tr);
         if (kind == K_TO) begin
            push_ev(E_TO, tr);
            n_tos++;
         end
         push_ev(E_FUP, tr + G);
         n_grants++;
      end
      bus.spi_req = 1'b1;
      while (cyc < end_c) begin
         bus.ft3_busy = (cyc < c0 + b);
         bus.spi_done = (kind == K_NORM || kind == K_COIN) && (cyc == tg + len - 1);
         if (kind == K_ABAN && cyc >= t + k) bus.spi_req = 1'b0;
         step();
      end
      bus.ft3_busy = 1'b0;
      bus.spi_done = 1'b0;
      ft3_start = (kind == K_ABAN) ? end_c : tr + G;
      // Stray done/busy while SPI does not own the lane must have no effect.
      for (int i = 0; i < gap; i++) begin
         bus.spi_req  = 1'b0;
         bus.spi_done = 1'($urandom_range(0, 1));
         bus.ft3_busy = 1'($urandom_range(0, 1));
         step();
      end
      bus.spi_done = 1'b0;
      bus.ft3_busy = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int kind, r, b, d, k, gap, t;
      bus.ft3_busy = 1'b0;
      bus.spi_req  = 1'b0;
      bus.spi_done = 1'b0;
`ifdef LANE_ARB_STATS_EN
      bus.stats_clr = 1'b0;
`endif
      #2 rst_n = 1'b0;
      repeat (3) step();
      chk("rst_ft3_grant", int'(bus.ft3_grant), 1);
      chk("rst_spi_grant", int'(bus.spi_grant), 0);
      chk("rst_switch", int'(bus.spi_switch), 0);
      chk("rst_timeout", int'(bus.spi_timeout), 0);
      chk("rst_state", int'(bus.arb_state), 0);
      rst_n = 1'b1;
      repeat (100) step();
      chk("idle_ft3_grant", int'(bus.ft3_grant), 1);
      chk("idle_switch", int'(bus.spi_switch), 0);
      chk("idle_state", int'(bus.arb_state), 0);

      // Directed: basic, back-to-back, FT3 busy, timeout, coincident done, abandon.
      run_txn(K_NORM, 0, 16, 1, 0);
      run_txn(K_NORM, 0, 3, 1, 5);
      run_txn(K_NORM, 50, 5, 1, 2);
      run_txn(K_TO, 0, 1, 1, 3);
      run_txn(K_COIN, 0, 1, 1, 3);
      run_txn(K_ABAN, 0, 1, 2, 4);

      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 99);
         kind = (r < 65) ? K_NORM : (r < 77) ? K_TO : (r < 85) ? K_COIN : K_ABAN;
         b = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 20);
         d = $urandom_range(1, MAX - 1);
         k = $urandom_range(1, G);
         gap = $urandom_range(0, 6);
         run_txn(kind, b, d, k, gap);
      end
      repeat (2 * G + 2) step();

`ifdef LANE_ARB_STATS_EN
      chk("stats_grants", int'(bus.spi_grant_cnt), n_grants);
      chk("stats_timeouts", int'(bus.spi_timeout_cnt), n_tos);
      bus.stats_clr = 1'b1;
      step();
      bus.stats_clr = 1'b0;
      chk("stats_clr_grants", int'(bus.spi_grant_cnt), 0);
      chk("stats_clr_timeouts", int'(bus.spi_timeout_cnt), 0);
`endif

      // Asynchronous reset in the middle of SPI ownership.
      t = handover_cycle(cyc, 0);
      push_ev(E_SWUP, t + 1);
      push_ev(E_GUP, t + 1 + G);
      bus.spi_req = 1'b1;
      while (cyc < t + 1 + G + 3) step();
      chk("mid_spi_grant", int'(bus.spi_grant), 1);
      bus.spi_req = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_spi_grant", int'(bus.spi_grant), 0);
      chk("async_switch", int'(bus.spi_switch), 0);
      chk("async_ft3_grant", int'(bus.ft3_grant), 1);
      chk("async_state", int'(bus.arb_state), 0);
      repeat (2) step();
      rst_n = 1'b1;
      ft3_start = -1000;
      run_txn(K_NORM, 0, 2, 1, 3);
      repeat (2 * G + 10) step();
      chk("events_pending", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
